// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
//
// Purpose:
//   Time-multiplexed driver for an NDIG-digit common-anode 7-segment display.
//   Hex nibbles and per-digit decimal points are captured into a pending
//   buffer. The buffer is copied into the displayed buffer only when the scan
//   wraps back to digit 0, so a frame never shows a mix of old and new data.
//   Only one digit is lit at a time, and all digits share one segment bus.
//
// Parameters:
//   NDIG         number of digits (1..8)
//   REFRESH_DIV  clk cycles spent on each digit slot (>= 2)
//
// Ports:
//   clk         in   1        system clock, rising edge
//   reset       in   1        synchronous, active-high
//   load        in   1        capture value/dp_in into the pending buffer
//   value       in   4*NDIG   digit i = value[4i+3:4i]
//   dp_in       in   NDIG     dp_in[i]=1 lights the decimal point of digit i
//   enable      in   1        0 blanks the display; the scan keeps running
//   anode       out  NDIG     active-low digit select
//   segments    out  8        active-low, [0]=a .. [6]=g, [7]=dp
//   frame_tick  out  1        one-cycle pulse after the scan wraps to digit 0
//
// Optional feature:
//   LEADING_ZERO_BLANK_EN: when defined, leading-zero digits other than digit
//   0 are blanked. Their decimal point still follows dp_in.
// -----------------------------------------------------------------------------
module hex_display_scanner #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              enable,
    output logic [NDIG-1:0]   anode,
    output logic [7:0]        segments,
    output logic              frame_tick
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    // Hex to active-low segments, returned in g..a order.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] pend_val_q, pend_val_d;
    logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NDIG-1:0] disp_val_q, disp_val_d;
    logic [NDIG-1:0]   disp_dp_q, disp_dp_d;
    logic [NDIG-1:0]   anode_q, anode_d;
    logic [7:0]        segments_q, segments_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_end_s;
    logic              wrap_s;
    logic [4*NDIG-1:0] upper_s;
    logic [NDIG-1:0]   dp_shift_s;
    logic [6:0]        glyph_s;

    // Scan counters and double-buffer next state.
    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        slot_end_s   = (presc_q == PRE_LAST);
        wrap_s       = slot_end_s && (idx_q == IDX_LAST);
        frame_tick_d = wrap_s;

        if (slot_end_s) begin
            presc_d = {PRE_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end

        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
        end else begin
            pend_val_d = pend_val_q;
            pend_dp_d  = pend_dp_q;
        end

        // A load on the wrap edge bypasses the pending buffer, so the new
        // data is shown in the frame that starts on that edge.
        if (wrap_s) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
            end else begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
        end else begin
            disp_val_d = disp_val_q;
            disp_dp_d  = disp_dp_q;
        end
    end

    // Select the digit for the current index and build the registered outputs.
    always_comb begin
        upper_s    = disp_val_q >> {idx_q, 2'b00};
        dp_shift_s = disp_dp_q >> idx_q;
        glyph_s    = decode_hex(upper_s[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        // This digit and every higher digit are zero, so it is a leading zero.
        if ((idx_q != {IDX_W{1'b0}}) && (upper_s == {(4*NDIG){1'b0}})) begin
            glyph_s = 7'h7F;
        end else begin
            glyph_s = decode_hex(upper_s[3:0]);
        end
`endif
        if (enable) begin
            anode_d    = ~(NDIG'(1) << idx_q);
            segments_d = {~dp_shift_s[0], glyph_s};
        end else begin
            anode_d    = {NDIG{1'b1}};
            segments_d = 8'hFF;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= {PRE_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            pend_val_q   <= {(4*NDIG){1'b0}};
            pend_dp_q    <= {NDIG{1'b0}};
            disp_val_q   <= {(4*NDIG){1'b0}};
            disp_dp_q    <= {NDIG{1'b0}};
            anode_q      <= {NDIG{1'b1}};
            segments_q   <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            anode_q      <= anode_d;
            segments_q   <= segments_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign segments   = segments_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_hex_display_scanner
//
// Directed bench for hex_display_scanner with NDIG=4 and REFRESH_DIV=4.
// Outputs are sampled on the falling clock edge. The expected values are
// hand-computed segment codes.
// -----------------------------------------------------------------------------
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        enable = 1'b1;
    logic [3:0]  anode;
    logic [7:0]  segments;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    hex_display_scanner #(.NDIG(4), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .enable     (enable),
        .anode      (anode),
        .segments   (segments),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Stop at the first falling edge where frame_tick is high. If none is
    // seen within the cycle bound, record a failure.
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        chk({tag, "_tick_seen"}, {7'd0, seen}, 8'd1);
    endtask

    // Starts at a falling edge where frame_tick is high. Checks the four
    // digit slots, then checks that the next tick comes 16 cycles later.
    task automatic check_digits(input string tag, input logic [7:0] s0,
                                input logic [7:0] s1, input logic [7:0] s2,
                                input logic [7:0] s3);
        logic [7:0] exp_seg [4];
        logic [3:0] an;
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 1 : 4) @(negedge clk);
            an = 4'b1111;
            an[d] = 1'b0;
            chk($sformatf("%s_an%0d", tag, d), {4'd0, anode}, {4'd0, an});
            chk($sformatf("%s_seg%0d", tag, d), segments, exp_seg[d]);
            chk($sformatf("%s_ft%0d", tag, d), {7'd0, frame_tick}, 8'd0);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_period"}, {7'd0, frame_tick}, 8'd1);
    endtask

    initial begin
        // Test 1: reset held for three cycles.
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_an", {4'd0, anode}, 8'h0F);
            chk("rst_seg", segments, 8'hFF);
            chk("rst_ft", {7'd0, frame_tick}, 8'd0);
        end
        reset = 1'b0;

        // Test 2: basic frame.
        load = 1'b1; value = 16'h12AF; dp_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        wait_frame("f12af");
        check_digits("f12af", 8'h8E, 8'h88, 8'hA4, 8'hF9);

        // Test 3a: two loads in one frame. The last load wins.
        load = 1'b1; value = 16'h0003;
        @(negedge clk);
        value = 16'h0005;
        @(negedge clk);
        load = 1'b0;
        // The current frame still shows the old data.
        chk("tear_seg0", segments, 8'h8E);
        wait_frame("f0005");
        check_digits("f0005", 8'h92, 8'hC0, 8'hC0, 8'hC0);

        // Test 3b: a load on the boundary edge is shown in that frame.
        repeat (15) @(negedge clk);
        load = 1'b1; value = 16'h8421;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_tick", {7'd0, frame_tick}, 8'd1);
        check_digits("f8421", 8'hF9, 8'hA4, 8'h99, 8'h80);

        // Test 4: blank for ten cycles. The scan continues underneath.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("blank_an", {4'd0, anode}, 8'h0F);
            chk("blank_seg", segments, 8'hFF);
            chk("blank_ft", {7'd0, frame_tick}, 8'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("reen_an", {4'd0, anode}, 8'h0B);
        chk("reen_seg", segments, 8'h99);
        repeat (5) @(negedge clk);
        chk("reen_period", {7'd0, frame_tick}, 8'd1);

        // Test 5: decimal point on digit 2 only.
        load = 1'b1; value = 16'h8421; dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0; dp_in = 4'b0000;
        wait_frame("fdp");
        check_digits("fdp", 8'hF9, 8'hA4, 8'h19, 8'h80);

        // Reset mid-scan discards the pending data.
        load = 1'b1; value = 16'hFFFF; dp_in = 4'b1111;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_an", {4'd0, anode}, 8'h0F);
        chk("mrst_seg", segments, 8'hFF);
        chk("mrst_ft", {7'd0, frame_tick}, 8'd0);
        reset = 1'b0; dp_in = 4'b0000;
        wait_frame("fzero");
`ifdef LEADING_ZERO_BLANK_EN
        check_digits("fzero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
        check_digits("fzero", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

        // Test 6: leading zeros.
        load = 1'b1; value = 16'h0030;
        @(negedge clk);
        load = 1'b0;
        wait_frame("f0030");
`ifdef LEADING_ZERO_BLANK_EN
        check_digits("f0030", 8'hC0, 8'hB0, 8'hFF, 8'hFF);
`else
        check_digits("f0030", 8'hC0, 8'hB0, 8'hC0, 8'hC0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
